reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Hazard controller for the in-order pipeline; sits beside the decode stage.
- Tracks in-flight writes per scalar register and for the condition code (CC).
- Decides each cycle whether the decoded instruction may issue, or must stall on a data dependency or an unresolved control transfer.
- Writeback traffic retires pending entries; a small FSM holds issue while a branch/jump is unresolved.

Parameters:
- NUM_RF, 16, number of scalar registers tracked.
- IDX_W, 4, register index width; must satisfy 2^IDX_W >= NUM_RF.
- CNT_W, 2, width of each per-register pending-write counter; max in-flight writes per register is 2^CNT_W-1.

Ports:
- I_CLOCK  in  1  pipeline clock; all state changes on posedge.
- I_RESET_N  in  1  asynchronous, active-low reset.
- I_IssueValid  in  1  decode holds a valid instruction (not fetch-stalled).
- I_Src1Use  in  1  instruction reads I_Src1Idx.
- I_Src1Idx  in  IDX_W  source 1 register.
- I_Src2Use  in  1  instruction reads I_Src2Idx.
- I_Src2Idx  in  IDX_W  source 2 register.
- I_DestUse  in  1  instruction writes I_DestIdx.
- I_DestIdx  in  IDX_W  destination register.
- I_SetsCC  in  1  instruction updates CC at writeback.
- I_UsesCC  in  1  instruction reads CC (conditional branches).
- I_IsCtrl  in  1  instruction is a branch/JMP/JSR/JSRR.
- I_BranchResolve  in  1  one-cycle pulse from execute: control transfer resolved.
- I_WbEnable  in  1  writeback this cycle.
- I_WbIdx  in  IDX_W  writeback register.
- I_WbSetsCC  in  1  writeback retires a CC-setting instruction.
- O_IssueGrant  out  1  instruction issues this cycle.
- O_DepStall  out  1  blocked by a data/CC hazard or counter saturation.
- O_BranchStall  out  1  blocked by an unresolved control transfer.
- O_PendingMask  out  NUM_RF  bit i = counter i nonzero (registered view).
- O_Underflow  out  1  sticky error flag.

Behaviour:
- Reset (async, I_RESET_N=0):
  - All counters and CC counter cleared; FSM to IDLE; O_Underflow=0.
  - Combinational outputs then evaluate to O_IssueGrant=0, O_DepStall=0, O_BranchStall=0, O_PendingMask=0.
  - A reset mid-operation discards all in-flight tracking.
- Register hazard, per used source s:
  - Hazard if cnt[s] != 0.
  - Exception: cnt[s]==1 and I_WbEnable and I_WbIdx==s (subject to the optional feature).
- CC hazard: I_UsesCC and cc_cnt != 0; the same single-pending writeback exception applies via I_WbSetsCC.
- Saturation: stall if I_DestUse and cnt[dest] is at its maximum, unless a same-cycle writeback to dest is retiring one entry.
- O_DepStall = I_IssueValid & state==IDLE & (any hazard | saturation).
- O_BranchStall = I_IssueValid & state==BR_WAIT.
- O_IssueGrant = I_IssueValid & state==IDLE & !O_DepStall. All three are combinational, zero latency.
- Counter update (posedge): next = cnt + (grant & DestUse & dest==i) - (WbEnable & WbIdx==i). Simultaneous increment and decrement nets to zero change. The CC counter updates identically.
- Underflow: a writeback to a zero counter (register, or CC when I_WbSetsCC) leaves the counter at 0 and sets O_Underflow until reset.
- FSM:
  - IDLE -> BR_WAIT when O_IssueGrant & I_IsCtrl.
  - BR_WAIT -> IDLE on I_BranchResolve.
  - A resolve in the same cycle as a stalled issue does not grant that cycle; the grant comes next cycle at earliest.
  - An I_BranchResolve in IDLE is ignored.
- Register 0 is tracked like any other register (no hardwired zero).

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: the same-cycle writeback exception applies, so a dependent instruction issues in the writeback cycle.
- Undefined: the exception is removed; a dependent instruction issues at earliest the cycle after writeback. The saturation exception is also removed.

Decomposition:
- Shared package/header (global_def.h): IDX_W/NUM_RF defaults, FSM state encodings (IDLE=0, BR_WAIT=1), counter max constant.
- One sub-module, sb_counter: a CNT_W up/down counter with inc, dec, underflow flag and nonzero output, instantiated NUM_RF+1 times (registers plus CC).

Test Plan:
- Issue ADD dest R3 (grant) -> O_PendingMask=0x0008 next cycle. Then issue with src1=R3 -> O_DepStall=1, O_IssueGrant=0. Writeback R3 -> with _EN grant in that cycle, without _EN grant the next cycle; mask returns to 0.
- Grant JSR (I_IsCtrl) -> next cycle valid instruction gives O_BranchStall=1 for 3 cycles. Pulse I_BranchResolve -> stall remains that cycle, grant the following cycle.
- Three back-to-back grants with dest R5 (CNT_W=2) -> cnt=3. Fourth gives O_DepStall=1 until a writeback to R5 (same cycle with _EN).
- Grant CC-setter, then BRZ (I_UsesCC) -> O_DepStall=1 until a writeback with I_WbSetsCC=1.
- Writeback R7 with no pending write -> O_Underflow=1 and stays set; mask bit 7 stays 0.
- Assert I_RESET_N=0 asynchronously in BR_WAIT with cnt[2]=2 -> all outputs 0 immediately; after release, an issue with src R2 grants.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: default sizes, FSM state
// encodings and the pending-counter ceiling helper.
package reg_scoreboard_pkg;

    localparam int RS_NUM_RF = 16;
    localparam int RS_IDX_W  = 4;
    localparam int RS_CNT_W  = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_BR_WAIT = 1'b1
    } sb_state_e;

    // Largest value a pending-write counter of width w can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int RS_CNT_MAX = (1 << RS_CNT_W) - 1;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down counter of in-flight writes for one register (or CC);
// flags an underflow event when a retire arrives with nothing pending.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = RS_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_nonzero,
    output logic             o_underflow
);

    localparam logic [CNT_W-1:0] L_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_underflow;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        w_count_next = r_count;
        w_underflow  = 1'b0;
        if (i_dec && (r_count == '0)) begin
            // Retire with nothing pending: stays at zero even if an issue
            // lands in the same cycle (+1 -1 nets to no change).
            w_underflow = 1'b1;
        end else if (i_inc && !i_dec) begin
            if (r_count != L_MAX) begin
                w_count_next = r_count + CNT_W'(1);
            end
        end else if (i_dec && !i_inc) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // NOTE: counters are state that must start clean after reset, so they are
    // reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count     = r_count;
    assign o_nonzero   = (r_count != '0);
    assign o_underflow = w_underflow;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-hazard controller beside decode: per-register and CC pending-write
// tracking plus a branch-wait FSM. Define SCOREBOARD_WB_BYPASS_EN to let a
// dependent instruction issue in the same cycle as the retiring writeback.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_RF = RS_NUM_RF,
    parameter int IDX_W  = RS_IDX_W,
    parameter int CNT_W  = RS_CNT_W
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET_N,
    input  logic              I_IssueValid,
    input  logic              I_Src1Use,
    input  logic [IDX_W-1:0]  I_Src1Idx,
    input  logic              I_Src2Use,
    input  logic [IDX_W-1:0]  I_Src2Idx,
    input  logic              I_DestUse,
    input  logic [IDX_W-1:0]  I_DestIdx,
    input  logic              I_SetsCC,
    input  logic              I_UsesCC,
    input  logic              I_IsCtrl,
    input  logic              I_BranchResolve,
    input  logic              I_WbEnable,
    input  logic [IDX_W-1:0]  I_WbIdx,
    input  logic              I_WbSetsCC,
    output logic              O_IssueGrant,
    output logic              O_DepStall,
    output logic              O_BranchStall,
    output logic [NUM_RF-1:0] O_PendingMask,
    output logic              O_Underflow
);

    localparam logic [CNT_W-1:0] L_CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0]  w_cnt [NUM_RF];
    logic [NUM_RF-1:0] w_inc;
    logic [NUM_RF-1:0] w_dec;
    logic [NUM_RF-1:0] w_nonzero;
    logic [NUM_RF-1:0] w_reg_uf;

    logic [CNT_W-1:0]  w_cc_cnt;
    logic              w_cc_inc;
    logic              w_cc_dec;
    logic              w_cc_nonzero;
    logic              w_cc_uf;

    logic [CNT_W-1:0]  w_src1_cnt;
    logic [CNT_W-1:0]  w_src2_cnt;
    logic [CNT_W-1:0]  w_dest_cnt;

    logic              w_src1_haz;
    logic              w_src2_haz;
    logic              w_cc_haz;
    logic              w_dest_sat;
    logic              w_cc_sat;
    logic              w_any_block;

    logic              w_issue_valid;
    logic              w_grant;
    logic              w_dep_stall;
    logic              w_br_stall;

    sb_state_e         r_state;
    sb_state_e         w_state_next;
    logic              r_underflow;

    // Pending-write counters, one per scalar register.
    for (genvar gi = 0; gi < NUM_RF; gi++) begin : g_rf_cnt
        assign w_inc[gi] = w_grant & I_DestUse & (I_DestIdx == IDX_W'(gi));
        assign w_dec[gi] = I_WbEnable & (I_WbIdx == IDX_W'(gi));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .i_clk       (I_CLOCK),
            .i_rst_n     (I_RESET_N),
            .i_inc       (w_inc[gi]),
            .i_dec       (w_dec[gi]),
            .o_count     (w_cnt[gi]),
            .o_nonzero   (w_nonzero[gi]),
            .o_underflow (w_reg_uf[gi])
        );
    end

    assign w_cc_inc = w_grant & I_SetsCC;
    assign w_cc_dec = I_WbEnable & I_WbSetsCC;

    sb_counter #(.CNT_W(CNT_W)) u_cc_cnt (
        .i_clk       (I_CLOCK),
        .i_rst_n     (I_RESET_N),
        .i_inc       (w_cc_inc),
        .i_dec       (w_cc_dec),
        .o_count     (w_cc_cnt),
        .o_nonzero   (w_cc_nonzero),
        .o_underflow (w_cc_uf)
    );

    // Look up the counters addressed by the decoded instruction.
    always_comb begin
        w_src1_cnt = '0;
        w_src2_cnt = '0;
        w_dest_cnt = '0;
        for (int i = 0; i < NUM_RF; i++) begin
            if (I_Src1Idx == IDX_W'(i)) w_src1_cnt = w_cnt[i];
            if (I_Src2Idx == IDX_W'(i)) w_src2_cnt = w_cnt[i];
            if (I_DestIdx == IDX_W'(i)) w_dest_cnt = w_cnt[i];
        end
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    logic w_src1_wb;
    logic w_src2_wb;
    logic w_dest_wb;

    assign w_src1_wb = I_WbEnable & (I_WbIdx == I_Src1Idx);
    assign w_src2_wb = I_WbEnable & (I_WbIdx == I_Src2Idx);
    assign w_dest_wb = I_WbEnable & (I_WbIdx == I_DestIdx);

    // A single pending write retiring this cycle no longer blocks its readers.
    assign w_src1_haz = I_Src1Use & (w_src1_cnt != '0)
                      & !((w_src1_cnt == CNT_W'(1)) & w_src1_wb);
    assign w_src2_haz = I_Src2Use & (w_src2_cnt != '0)
                      & !((w_src2_cnt == CNT_W'(1)) & w_src2_wb);
    assign w_cc_haz   = I_UsesCC & w_cc_nonzero
                      & !((w_cc_cnt == CNT_W'(1)) & w_cc_dec);
    assign w_dest_sat = I_DestUse & (w_dest_cnt == L_CNT_MAX) & !w_dest_wb;
    assign w_cc_sat   = I_SetsCC & (w_cc_cnt == L_CNT_MAX) & !w_cc_dec;
`else
    assign w_src1_haz = I_Src1Use & (w_src1_cnt != '0);
    assign w_src2_haz = I_Src2Use & (w_src2_cnt != '0);
    assign w_cc_haz   = I_UsesCC & w_cc_nonzero;
    assign w_dest_sat = I_DestUse & (w_dest_cnt == L_CNT_MAX);
    assign w_cc_sat   = I_SetsCC & (w_cc_cnt == L_CNT_MAX);
`endif

    assign w_any_block = w_src1_haz | w_src2_haz | w_cc_haz | w_dest_sat | w_cc_sat;

    // Reset forces the combinational outputs low even if decode holds valid.
    assign w_issue_valid = I_IssueValid & I_RESET_N;

    always_comb begin
        w_dep_stall  = 1'b0;
        w_br_stall   = 1'b0;
        w_grant      = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                w_dep_stall = w_issue_valid & w_any_block;
                w_grant     = w_issue_valid & !w_any_block;
                if (w_grant && I_IsCtrl) begin
                    w_state_next = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                // Resolve only reopens issue from the next cycle on.
                w_br_stall = w_issue_valid;
                if (I_BranchResolve) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state     <= ST_IDLE;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_underflow <= r_underflow | (|w_reg_uf) | w_cc_uf;
        end
    end

    assign O_IssueGrant  = w_grant;
    assign O_DepStall    = w_dep_stall;
    assign O_BranchStall = w_br_stall;
    assign O_PendingMask = w_nonzero;
    assign O_Underflow   = r_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_reg_scoreboard;

    localparam int NUM_RF = 16;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = 2;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic              I_CLOCK;
    logic              I_RESET_N;
    logic              I_IssueValid;
    logic              I_Src1Use;
    logic [IDX_W-1:0]  I_Src1Idx;
    logic              I_Src2Use;
    logic [IDX_W-1:0]  I_Src2Idx;
    logic              I_DestUse;
    logic [IDX_W-1:0]  I_DestIdx;
    logic              I_SetsCC;
    logic              I_UsesCC;
    logic              I_IsCtrl;
    logic              I_BranchResolve;
    logic              I_WbEnable;
    logic [IDX_W-1:0]  I_WbIdx;
    logic              I_WbSetsCC;
    logic              O_IssueGrant;
    logic              O_DepStall;
    logic              O_BranchStall;
    logic [NUM_RF-1:0] O_PendingMask;
    logic              O_Underflow;

    typedef struct {
        string       name;
        logic        g;
        logic        d;
        logic        b;
        logic [15:0] m;
        logic        u;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_scoreboard #(.NUM_RF(NUM_RF), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .I_CLOCK         (I_CLOCK),
        .I_RESET_N       (I_RESET_N),
        .I_IssueValid    (I_IssueValid),
        .I_Src1Use       (I_Src1Use),
        .I_Src1Idx       (I_Src1Idx),
        .I_Src2Use       (I_Src2Use),
        .I_Src2Idx       (I_Src2Idx),
        .I_DestUse       (I_DestUse),
        .I_DestIdx       (I_DestIdx),
        .I_SetsCC        (I_SetsCC),
        .I_UsesCC        (I_UsesCC),
        .I_IsCtrl        (I_IsCtrl),
        .I_BranchResolve (I_BranchResolve),
        .I_WbEnable      (I_WbEnable),
        .I_WbIdx         (I_WbIdx),
        .I_WbSetsCC      (I_WbSetsCC),
        .O_IssueGrant    (O_IssueGrant),
        .O_DepStall      (O_DepStall),
        .O_BranchStall   (O_BranchStall),
        .O_PendingMask   (O_PendingMask),
        .O_Underflow     (O_Underflow)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", n, act, exp);
        end
    endtask

    task automatic clr();
        I_IssueValid    = 1'b0;
        I_Src1Use       = 1'b0;
        I_Src1Idx       = '0;
        I_Src2Use       = 1'b0;
        I_Src2Idx       = '0;
        I_DestUse       = 1'b0;
        I_DestIdx       = '0;
        I_SetsCC        = 1'b0;
        I_UsesCC        = 1'b0;
        I_IsCtrl        = 1'b0;
        I_BranchResolve = 1'b0;
        I_WbEnable      = 1'b0;
        I_WbIdx         = '0;
        I_WbSetsCC      = 1'b0;
    endtask

    task automatic go();
        @(posedge I_CLOCK);
        #1;
        clr();
    endtask

    task automatic exp_push(input string n, input logic g, input logic d, input logic b,
                            input logic [15:0] m, input logic u);
        exp_t e;
        e.name = n;
        e.g    = g;
        e.d    = d;
        e.b    = b;
        e.m    = m;
        e.u    = u;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge I_CLOCK);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({e.name, ".grant"},  32'(O_IssueGrant),  32'(e.g));
                check({e.name, ".dep"},    32'(O_DepStall),    32'(e.d));
                check({e.name, ".br"},     32'(O_BranchStall), 32'(e.b));
                check({e.name, ".mask"},   32'(O_PendingMask), 32'(e.m));
                check({e.name, ".uflow"},  32'(O_Underflow),   32'(e.u));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        I_RESET_N = 1'b0;
        clr();

        go(); I_IssueValid = 1; exp_push("in_reset", 0, 0, 0, 16'h0000, 0);
        go(); I_RESET_N = 1;    exp_push("post_reset", 0, 0, 0, 16'h0000, 0);

        // RAW on R3
        go(); I_IssueValid = 1; I_DestUse = 1; I_DestIdx = 3;
        exp_push("add_r3", 1, 0, 0, 16'h0000, 0);
        go(); I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 3;
        exp_push("raw_r3", 0, 1, 0, 16'h0008, 0);
        go(); I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 3; I_WbEnable = 1; I_WbIdx = 3;
        exp_push("raw_r3_wb", BYP, !BYP, 0, 16'h0008, 0);
        go(); I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 3;
        exp_push("raw_r3_after", 1, 0, 0, 16'h0000, 0);

        // Control transfer wait
        go(); I_IssueValid = 1; I_IsCtrl = 1;
        exp_push("jsr", 1, 0, 0, 16'h0000, 0);
        go(); I_IssueValid = 1; exp_push("br_wait0", 0, 0, 1, 16'h0000, 0);
        go(); I_IssueValid = 1; exp_push("br_wait1", 0, 0, 1, 16'h0000, 0);
        go(); I_IssueValid = 1; I_BranchResolve = 1;
        exp_push("br_resolve", 0, 0, 1, 16'h0000, 0);
        go(); I_IssueValid = 1; exp_push("br_done", 1, 0, 0, 16'h0000, 0);

        // Saturation on R5
        for (int k = 0; k < 3; k++) begin
            go(); I_IssueValid = 1; I_DestUse = 1; I_DestIdx = 5;
            exp_push("sat_fill", 1, 0, 0, (k == 0) ? 16'h0000 : 16'h0020, 0);
        end
        go(); I_IssueValid = 1; I_DestUse = 1; I_DestIdx = 5;
        exp_push("sat_stall", 0, 1, 0, 16'h0020, 0);
        go(); I_IssueValid = 1; I_DestUse = 1; I_DestIdx = 5; I_WbEnable = 1; I_WbIdx = 5;
        exp_push("sat_wb", BYP, !BYP, 0, 16'h0020, 0);
        for (int k = 0; k < (BYP ? 3 : 2); k++) begin
            go(); I_WbEnable = 1; I_WbIdx = 5;
            exp_push("sat_drain", 0, 0, 0, 16'h0020, 0);
        end

        // CC dependency
        go(); I_IssueValid = 1; I_SetsCC = 1; I_DestUse = 1; I_DestIdx = 1;
        exp_push("cc_set", 1, 0, 0, 16'h0000, 0);
        go(); I_IssueValid = 1; I_UsesCC = 1; I_IsCtrl = 1;
        exp_push("brz_stall", 0, 1, 0, 16'h0002, 0);
        go(); I_IssueValid = 1; I_UsesCC = 1; I_IsCtrl = 1;
        I_WbEnable = 1; I_WbIdx = 1; I_WbSetsCC = 1;
        exp_push("brz_wb", BYP, !BYP, 0, 16'h0002, 0);
        go(); I_IssueValid = 1; I_UsesCC = 1; I_IsCtrl = 1; I_BranchResolve = 1;
        exp_push("brz_next", !BYP, 0, BYP, 16'h0000, 0);
        go(); I_BranchResolve = 1;
        exp_push("brz_resolve", 0, 0, 0, 16'h0000, 0);
        go(); I_IssueValid = 1; exp_push("idle_ok", 1, 0, 0, 16'h0000, 0);

        // Underflow on R7
        go(); I_WbEnable = 1; I_WbIdx = 7;
        exp_push("uf_wb7", 0, 0, 0, 16'h0000, 0);
        go(); exp_push("uf_set", 0, 0, 0, 16'h0000, 1);
        go(); I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 7;
        exp_push("uf_sticky", 1, 0, 0, 16'h0000, 1);

        // Async reset while in BR_WAIT with two writes pending on R2
        go(); I_IssueValid = 1; I_DestUse = 1; I_DestIdx = 2;
        exp_push("r2_a", 1, 0, 0, 16'h0000, 1);
        go(); I_IssueValid = 1; I_DestUse = 1; I_DestIdx = 2; I_IsCtrl = 1;
        exp_push("r2_b_jmp", 1, 0, 0, 16'h0004, 1);
        go(); I_IssueValid = 1; exp_push("r2_br_wait", 0, 0, 1, 16'h0004, 1);
        go(); I_IssueValid = 1; I_RESET_N = 0;
        exp_push("async_rst", 0, 0, 0, 16'h0000, 0);
        go(); I_RESET_N = 1; I_IssueValid = 1; I_Src1Use = 1; I_Src1Idx = 2;
        exp_push("post_rst_r2", 1, 0, 0, 16'h0000, 0);
        go(); exp_push("final_idle", 0, 0, 0, 16'h0000, 0);

        go();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge I_CLOCK);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
